// File: rtl/dm_bus_ctrl.sv
// dm_bus_ctrl: CPU-side bus controller that routes single accesses to a
// synchronous-read DMEM port or to a small bank of 32-bit MMIO registers.
//
// Optional feature macro: DM_BUS_ERR_EN
//   Defined   -> unmapped addresses and misaligned byte enables are rejected
//                with err=1 and no memory/register side effects.
//   Undefined -> err is tied low and byte enables pass through unchecked.
//
// Ports
//   clk_in, rst            clock, asynchronous active-low reset
//   req, we, addr,
//   wdata, byte_ena        CPU request (req held until ready)
//   rdata, ready, err      CPU response (valid while ready=1)
//   dm_en, dm_we, dm_addr,
//   dm_be, dm_wdata        DMEM command port
//   dm_rdata               DMEM read data (one-cycle synchronous)
//   io_out                 MMIO register contents, channel k at [32k+31:32k]
module dm_bus_ctrl #(
    parameter logic [31:0] DM_BASE  = 32'h1001_0000,
    parameter int unsigned DM_AW    = 11,
    parameter logic [31:0] IO_BASE  = 32'h1002_0000,
    parameter int unsigned IO_CH    = 4,
    parameter int unsigned WAIT_CYC = 1
) (
    input  logic                   clk_in,
    input  logic                   rst,
    input  logic                   req,
    input  logic                   we,
    input  logic [31:0]            addr,
    input  logic [31:0]            wdata,
    input  logic [3:0]             byte_ena,
    output logic [31:0]            rdata,
    output logic                   ready,
    output logic                   err,
    output logic                   dm_en,
    output logic                   dm_we,
    output logic [DM_AW+1:0]       dm_addr,
    output logic [3:0]             dm_be,
    output logic [31:0]            dm_wdata,
    input  logic [31:0]            dm_rdata,
    output logic [32*IO_CH-1:0]    io_out
);

    localparam int unsigned ADDR_W = DM_AW + 2;
    localparam int unsigned IO_IW  = (IO_CH > 1) ? $clog2(IO_CH) : 1;
    localparam logic [3:0]  CNT_LAST = 4'(WAIT_CYC - 1);
    // 33-bit region ends so a region touching the top of the map cannot wrap
    localparam logic [32:0] DM_END = {1'b0, DM_BASE} + (33'd1 << ADDR_W);
    localparam logic [32:0] IO_END = {1'b0, IO_BASE} + 33'(4 * IO_CH);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    typedef enum logic [1:0] {K_NONE, K_DM, K_IO} kind_t;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    kind_t              kind_q, kind_c;
    logic               we_q;
    logic [IO_IW-1:0]   io_idx_q;
    logic               hit_dm_c, hit_io_c, bad_c;
    logic               accept_c, last_c, io_wr_c;
    logic               ready_d, dm_en_d, dm_we_d;
    logic [31:0]        rdata_d, io_rd_c;

    // Region decode of the incoming address
    assign hit_dm_c = ({1'b0, addr} >= {1'b0, DM_BASE}) && ({1'b0, addr} < DM_END);
    assign hit_io_c = ({1'b0, addr} >= {1'b0, IO_BASE}) && ({1'b0, addr} < IO_END);

`ifdef DM_BUS_ERR_EN
    logic be_ok_c;
    logic bad_q;
    logic err_d;

    // Legal lane patterns: naturally aligned byte, halfword or word
    always_comb begin
        case (addr[1:0])
            2'd0:    be_ok_c = (byte_ena == 4'b0001) || (byte_ena == 4'b0011) ||
                               (byte_ena == 4'b1111);
            2'd1:    be_ok_c = (byte_ena == 4'b0010);
            2'd2:    be_ok_c = (byte_ena == 4'b0100) || (byte_ena == 4'b1100);
            default: be_ok_c = (byte_ena == 4'b1000);
        endcase
    end

    assign bad_c = !(hit_dm_c || hit_io_c) || !be_ok_c;
`else
    assign bad_c = 1'b0;
    assign err   = 1'b0;
`endif

    // Access class latched at acceptance; rejected accesses behave as unmapped
    always_comb begin
        kind_c = K_NONE;
        if (!bad_c) begin
            if (hit_dm_c)      kind_c = K_DM;
            else if (hit_io_c) kind_c = K_IO;
        end
    end

    // MMIO read mux
    always_comb begin
        io_rd_c = 32'h0;
        for (int k = 0; k < int'(IO_CH); k++) begin
            if (io_idx_q == IO_IW'(k)) io_rd_c = io_out[32*k +: 32];
        end
    end

    // State register
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and next values of the registered outputs
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        accept_c = 1'b0;
        last_c   = 1'b0;
        ready_d  = 1'b0;
        dm_en_d  = 1'b0;
        dm_we_d  = 1'b0;
        rdata_d  = rdata;
`ifdef DM_BUS_ERR_EN
        err_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (req) begin
                    accept_c = 1'b1;
                    state_d  = ACCESS;
                    cnt_d    = 4'd0;
                    dm_en_d  = (kind_c == K_DM);
                    dm_we_d  = (kind_c == K_DM) && we;
                end
            end
            ACCESS: begin
                if (cnt_q == CNT_LAST) begin
                    last_c  = 1'b1;
                    state_d = RESP;
                    cnt_d   = 4'd0;
                    ready_d = 1'b1;
                    if (we_q)                rdata_d = 32'h0;
                    else if (kind_q == K_DM) rdata_d = dm_rdata;
                    else if (kind_q == K_IO) rdata_d = io_rd_c;
                    else                     rdata_d = 32'h0;
`ifdef DM_BUS_ERR_EN
                    err_d   = bad_q;
`endif
                end else begin
                    dm_en_d = dm_en;
                    cnt_d   = cnt_q + 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign io_wr_c = last_c && we_q && (kind_q == K_IO);

    // Request capture, response and DMEM command registers
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            kind_q   <= K_NONE;
            we_q     <= 1'b0;
            io_idx_q <= '0;
            ready    <= 1'b0;
            rdata    <= 32'h0;
            dm_en    <= 1'b0;
            dm_we    <= 1'b0;
            dm_addr  <= '0;
            dm_be    <= 4'h0;
            dm_wdata <= 32'h0;
        end else begin
            ready <= ready_d;
            rdata <= rdata_d;
            dm_en <= dm_en_d;
            dm_we <= dm_we_d;
            if (accept_c) begin
                kind_q   <= kind_c;
                we_q     <= we;
                io_idx_q <= IO_IW'((addr - IO_BASE) >> 2);
                dm_addr  <= ADDR_W'(addr - DM_BASE);
                dm_be    <= byte_ena;
                dm_wdata <= wdata;
            end
        end
    end

`ifdef DM_BUS_ERR_EN
    // Error flag, reported alongside ready
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            bad_q <= 1'b0;
            err   <= 1'b0;
        end else begin
            err <= err_d;
            if (accept_c) bad_q <= bad_c;
        end
    end
`endif

    // MMIO registers: lane-masked write on the ACCESS->RESP edge
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            io_out <= '0;
        end else if (io_wr_c) begin
            for (int k = 0; k < int'(IO_CH); k++) begin
                for (int b = 0; b < 4; b++) begin
                    if ((io_idx_q == IO_IW'(k)) && dm_be[b]) begin
                        io_out[32*k + 8*b +: 8] <= dm_wdata[8*b +: 8];
                    end
                end
            end
        end
    end

endmodule
